// File: rtl/bit_16.sv
`default_nettype none
// ============================================================================
// Module   : bit_16
// Purpose  : Two-lane partial-product combiner for 16x16 unsigned multiply.
//            An external 8x8 multiplier array presents one partial product
//            per lane per cycle in the fixed order AL*BL, AL*BH, AH*BL,
//            AH*BH. Each lane shifts and accumulates the four partial
//            products into a 32-bit accumulator and registers the low
//            16 bits of the full product.
// Ports    : clk        - clock, rising edge
//            rst        - asynchronous active-low reset
//            start      - begin an operation (sampled only in IDLE)
//            mult_out1  - lane-1 partial product for the current step
//            mult_out2  - lane-2 partial product for the current step
//            product1   - lane-1 result, low 16 bits, registered
//            product2   - lane-2 result, low 16 bits, registered
//            done       - one-cycle pulse while in DONE (BIT_16_DONE_EN only)
// Options  : `define BIT_16_DONE_EN to add the done output port.
// Revision : 1.0 - initial release
// ============================================================================
module bit_16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] mult_out1,
    input  logic [15:0] mult_out2,
    output logic [15:0] product1,
    output logic [15:0] product2
`ifdef BIT_16_DONE_EN
    ,
    output logic        done
`endif
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_0    = 3'd1;
    localparam logic [2:0] S_1    = 3'd2;
    localparam logic [2:0] S_2    = 3'd3;
    localparam logic [2:0] S_3    = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [31:0] acc1_q,  acc1_d;
    logic [31:0] acc2_q,  acc2_d;
    logic [15:0] prod1_q, prod1_d;
    logic [15:0] prod2_q, prod2_d;

    function automatic logic [31:0] zext16(input logic [15:0] v);
        return {16'h0000, v};
    endfunction

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: fixed four-step sequence, then one DONE cycle
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = start ? S_0 : S_IDLE;
            S_0:     state_d = S_1;
            S_1:     state_d = S_2;
            S_2:     state_d = S_3;
            S_3:     state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next-state: shift-and-accumulate for both lanes.
    // S0 loads rather than adds, so a stale accumulator never leaks in.
    // At S3 the accumulator receives the full 32-bit product and the
    // low half is captured into the product register on the same edge.
    // ------------------------------------------------------------------
    always_comb begin
        acc1_d  = acc1_q;
        acc2_d  = acc2_q;
        prod1_d = prod1_q;
        prod2_d = prod2_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc1_d = 32'h0;
                    acc2_d = 32'h0;
                end
            end
            S_0: begin
                acc1_d = zext16(mult_out1);
                acc2_d = zext16(mult_out2);
            end
            S_1, S_2: begin
                acc1_d = acc1_q + (zext16(mult_out1) << 8);
                acc2_d = acc2_q + (zext16(mult_out2) << 8);
            end
            S_3: begin
                acc1_d  = acc1_q + (zext16(mult_out1) << 16);
                acc2_d  = acc2_q + (zext16(mult_out2) << 16);
                prod1_d = acc1_d[15:0];
                prod2_d = acc2_d[15:0];
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc1_q  <= 32'h0;
            acc2_q  <= 32'h0;
            prod1_q <= 16'h0;
            prod2_q <= 16'h0;
        end else begin
            acc1_q  <= acc1_d;
            acc2_q  <= acc2_d;
            prod1_q <= prod1_d;
            prod2_q <= prod2_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign product1 = prod1_q;
    assign product2 = prod2_q;

`ifdef BIT_16_DONE_EN
    // Decoded straight from the state register, so it is low in reset and
    // high exactly for the cycle the new products first appear.
    always_comb begin
        done = (state_q == S_DONE);
    end
`else
    // No completion flag in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_bit_16.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit_16
// Purpose  : Self-checking bench for bit_16 using a table of directed
//            partial-product vectors plus hand-written multi-cycle sequences
//            (reset abort, idle hold, back-to-back with start held high).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bit_16;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] mult_out1;
    logic [15:0] mult_out2;
    logic [15:0] product1;
    logic [15:0] product2;
`ifdef BIT_16_DONE_EN
    logic        done;
`endif

    int n_tests;
    int n_fail;

    bit_16 dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mult_out1 (mult_out1),
        .mult_out2 (mult_out2),
        .product1  (product1),
        .product2  (product2)
`ifdef BIT_16_DONE_EN
        ,
        .done      (done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [3:0][15:0] pp1;   // index 0 = S0 ... index 3 = S3
        logic [3:0][15:0] pp2;
        logic [15:0]      exp1;
        logic [15:0]      exp2;
    } vec_t;

    vec_t vecs[4];

    task automatic check16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", nm, act, exp);
        end
    endtask

    task automatic check1(input string nm, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one operation starting from IDLE; returns one cycle after E5
    // (back in IDLE). keep_start holds start high for the whole operation.
    task automatic run_op(input string nm, input logic [3:0][15:0] p1,
                          input logic [3:0][15:0] p2, input logic [15:0] e1,
                          input logic [15:0] e2, input logic keep_start);
        logic [15:0] prev1;
        logic [15:0] prev2;
        prev1     = product1;
        prev2     = product2;
        start     = 1'b1;
        mult_out1 = 16'hDEAD;
        mult_out2 = 16'hBEEF;
        tick();                                 // E0
        start = keep_start;
        for (int i = 0; i < 4; i++) begin
            mult_out1 = p1[i];
            mult_out2 = p2[i];
            tick();                             // E1..E4
            if (i < 3) begin
                check16({nm, " hold1"}, product1, prev1);
                check16({nm, " hold2"}, product2, prev2);
            end
        end
        check16({nm, " product1"}, product1, e1);
        check16({nm, " product2"}, product2, e2);
`ifdef BIT_16_DONE_EN
        check1({nm, " done high"}, done, 1'b1);
`endif
        mult_out1 = 16'h5A5A;
        mult_out2 = 16'hA5A5;
        tick();                                 // E5
`ifdef BIT_16_DONE_EN
        check1({nm, " done low"}, done, 1'b0);
`endif
        check16({nm, " after1"}, product1, e1);
        check16({nm, " after2"}, product2, e2);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b0;
        start     = 1'b0;
        mult_out1 = 16'h0;
        mult_out2 = 16'h0;

        // 0x5678*0x1234 = 0x06260060
        vecs[0] = '{"nominal", {16'h060C, 16'h1178, 16'h0870, 16'h1860},
                               {16'h060C, 16'h1178, 16'h0870, 16'h1860},
                               16'h0060, 16'h0060};
        // lane1 0xFFFF*0xFFFF = 0xFFFE0001, lane2 0x0002*0x0003 = 6
        vecs[1] = '{"indep", {16'hFE01, 16'hFE01, 16'hFE01, 16'hFE01},
                             {16'h0000, 16'h0000, 16'h0000, 16'h0006},
                             16'h0001, 16'h0006};
        // lane1 0x00FF*0x0101 = 0xFFFF, lane2 0x1234*0x0001 = 0x1234
        vecs[2] = '{"mixed", {16'h0000, 16'h0000, 16'h00FF, 16'h00FF},
                             {16'h0000, 16'h0012, 16'h0000, 16'h0034},
                             16'hFFFF, 16'h1234};
        // 0x0100*0x0100 = 0x00010000, low half zero
        vecs[3] = '{"highonly", {16'h0001, 16'h0000, 16'h0000, 16'h0000},
                                {16'h0001, 16'h0000, 16'h0000, 16'h0000},
                                16'h0000, 16'h0000};

        // Reset state
        tick();
        tick();
        check16("reset product1", product1, 16'h0000);
        check16("reset product2", product2, 16'h0000);
`ifdef BIT_16_DONE_EN
        check1("reset done", done, 1'b0);
`endif
        rst = 1'b1;
        tick();

        // Table-driven operations (start dropped right after E0)
        for (int v = 0; v < 4; v++) begin
            run_op(vecs[v].name, vecs[v].pp1, vecs[v].pp2,
                   vecs[v].exp1, vecs[v].exp2, 1'b0);
            tick();
        end

        // Load a known value, then idle with garbage and start low
        run_op("preload", vecs[0].pp1, vecs[0].pp2, 16'h0060, 16'h0060, 1'b0);
        mult_out1 = 16'hFFFF;
        mult_out2 = 16'h1357;
        for (int i = 0; i < 4; i++) tick();
        check16("idle hold1", product1, 16'h0060);
        check16("idle hold2", product2, 16'h0060);

        // Back-to-back with start held high: second E0 is E6
        run_op("b2b first", vecs[0].pp1, vecs[0].pp2, 16'h0060, 16'h0060, 1'b1);
        run_op("b2b second", vecs[3].pp1, vecs[3].pp2, 16'h0000, 16'h0000, 1'b1);
        start = 1'b0;
        tick();

        // Reset mid-S2 with nonzero partial sums and nonzero products
        run_op("pre-abort", vecs[1].pp1, vecs[1].pp2, 16'h0001, 16'h0006, 1'b0);
        start = 1'b1;
        tick();                                 // E0
        start     = 1'b0;
        mult_out1 = 16'h1860;
        mult_out2 = 16'hFE01;
        tick();                                 // E1
        mult_out1 = 16'h0870;
        mult_out2 = 16'hFE01;
        tick();                                 // E2, now in S2
        rst = 1'b0;
        #1;
        check16("abort product1", product1, 16'h0000);
        check16("abort product2", product2, 16'h0000);
`ifdef BIT_16_DONE_EN
        check1("abort done", done, 1'b0);
`endif
        tick();
        rst       = 1'b1;
        mult_out1 = 16'hFFFF;
        mult_out2 = 16'hFFFF;
        tick();
        tick();
        check16("post-abort idle1", product1, 16'h0000);
        check16("post-abort idle2", product2, 16'h0000);
        run_op("fresh", vecs[2].pp1, vecs[2].pp2, 16'hFFFF, 16'h1234, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
